word_bit_assembler: RTL and testbench
=====================================

// Module: word_bit_assembler
// PURPOSE
//  Writer side of the bit-select path: builds a WIDTH-bit word one indexed bit at a time.
//  Each beat (idx, bit) writes word[idx]. A completed word is presented on a valid/ready
//  output port for any downstream bit-select reader. Sits between a serial/bit-granular
//  producer and a word-wide consumer.
// PARAMETERS
//  WIDTH   16       word width in bits; any value >= 2
//  IDX_W   $clog2(WIDTH)+1  index width; extra MSB allows out-of-range detection
//  INIT    '0       WIDTH-bit value loaded into the word at reset and after each handoff
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block accepts beat; accept = in_valid & in_ready
//  in_idx     in   IDX_W  target bit position
//  in_bit     in   1      value written to word[in_idx]
//  in_last    in   1      force completion with this beat
//  out_valid  out  1      out_word/out_mask hold a completed word
//  out_ready  in   1      consumer takes word; handoff = out_valid & out_ready
//  out_word   out  WIDTH  assembled word
//  out_mask   out  WIDTH  1 per bit written since the last handoff
//  err_idx    out  1      one-cycle pulse: accepted beat had in_idx >= WIDTH
// BEHAVIOUR
//  Reset (async assert, sync release): state=FILL, word=INIT, mask=0, out_valid=0,
//   err_idx=0; in_ready=1 from the first edge after release.
//  States: FILL (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
//  in_ready and out_valid decode from state only; no combinational path from in_* or out_ready.
//  FILL, accepted beat with in_idx < WIDTH: word[in_idx]<=in_bit, mask[in_idx]<=1.
//  Duplicate index: the later write wins; the mask bit stays 1.
//  Accepted beat with in_idx >= WIDTH: word and mask unchanged; err_idx=1 on the next cycle.
//  Completion: the accepted beat leaves mask all-ones, or in_last=1 -> HOLD next cycle.
//   Latency from the completing beat to out_valid is 1 cycle.
//  in_last on an out-of-range beat still completes, with a partial mask.
//  HOLD: out_word/out_mask stable, holding even when out_ready=0.
//  On handoff: word<=INIT, mask<=0, state->FILL; in_ready=1 the following cycle.
//  No bypass: a beat cannot be accepted in the handoff cycle.
//  Max throughput: WIDTH beats + 1 handoff cycle per word.
//  in_idx, in_bit and in_last are ignored when in_valid=0 or when in HOLD.
//  rst_n assert mid-word or in HOLD: partial or pending word discarded; reset values apply.
// STRUCTURE
//  Package word_asm_pkg:
//   - state_e enum {FILL, HOLD}
//   - DEF_WIDTH=16
//   - function all_ones(mask)
//  Sub-module bit_lane_decoder (in_idx, en) -> one-hot WIDTH write enable, plus out_of_range
//   flag. Used for both the word and mask updates.
//  Top level holds the FSM and the word/mask registers only.
// TESTING
//  1 Reset then 16 beats idx 0..15, bits of 16'habcd, in_last=0 -> after the 16th beat:
//    out_valid=1, out_word=16'habcd, out_mask=16'hffff.
//  2 Beats idx 3 bit 1, idx 3 bit 0, idx 5 bit 1 with in_last -> out_word=16'h0020,
//    out_mask=16'h0028.
//  3 Beat idx 16 (WIDTH=16) -> err_idx pulses 1 cycle; word and mask unchanged.
//    Then a beat idx 17 with in_last -> HOLD with out_mask=0.
//  4 Hold out_ready=0 for 10 cycles after completion -> in_ready=0 and out_word stable.
//    out_ready=1 -> next cycle in_ready=1 and mask=0.
//  5 Fill 8 bits, then assert rst_n=0 asynchronously mid-cycle -> outputs at reset values
//    immediately; a fresh 16-beat fill yields the correct word.
//  6 Random valid/ready gaps, 1000 words against a scoreboard model -> no lost or duplicated
//    word; every out_word matches the model.

Source files
------------

// File: rtl/word_asm_pkg.sv
// word_asm_pkg: shared FSM state, default width and mask-completion helper for the word bit assembler
package word_asm_pkg;
  typedef enum logic {FILL, HOLD} state_e;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_W = 1024;
  function automatic logic all_ones(input logic [MAX_W-1:0] mask, input int width);
    return ~|(~mask & ((MAX_W'(1) << width) - MAX_W'(1)));
  endfunction
endpackage

// File: rtl/bit_lane_decoder.sv
// bit_lane_decoder: one-hot lane write enable from a bit index (idx, en -> we), plus out_of_range when idx >= WIDTH
module bit_lane_decoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH) + 1
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] we,
  output logic             out_of_range
);
  always_comb begin
    out_of_range = 32'(idx) >= WIDTH;
    we = (en && !out_of_range) ? WIDTH'(1) << idx : '0;
  end
endmodule

// File: rtl/word_bit_assembler.sv
// word_bit_assembler: builds a WIDTH-bit word from indexed bit beats (in_valid/in_ready/in_idx/in_bit/in_last) and hands it off on out_valid/out_ready with out_word/out_mask; err_idx flags out-of-range beats
module word_bit_assembler
  import word_asm_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               IDX_W = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [WIDTH-1:0] out_mask,
  output logic             err_idx
);
  state_e state, state_nx;
  logic [WIDTH-1:0] word, mask, we, word_nx, mask_nx;
  logic oor, accept, handoff, done;
  assign in_ready = state == FILL;
  assign out_valid = state == HOLD;
  assign accept = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  assign out_word = word;
  assign out_mask = mask;
  bit_lane_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
    .idx(in_idx),
    .en(accept),
    .we(we),
    .out_of_range(oor)
  );
  always_comb begin
    word_nx = handoff ? INIT : (word & ~we) | (we & {WIDTH{in_bit}});
    mask_nx = handoff ? '0 : mask | we;
    done = accept & (in_last | all_ones(MAX_W'(mask | we), WIDTH));
    state_nx = done ? HOLD : handoff ? FILL : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      word <= INIT;
      mask <= '0;
      err_idx <= 1'b0;
    end else begin
      state <= state_nx;
      word <= word_nx;
      mask <= mask_nx;
      err_idx <= accept & oor;
    end
  end
endmodule

// File: tb/tb_word_bit_assembler.sv
// tb_word_bit_assembler: directed and random scoreboard bench for word_bit_assembler
module tb_word_bit_assembler;
  localparam int W = 16;
  typedef struct packed {logic [W-1:0] w; logic [W-1:0] m;} item_t;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [4:0] in_idx = '0;
  logic in_ready, out_valid, err_idx;
  logic [W-1:0] out_word, out_mask;
  int errors = 0, checks = 0;
  item_t q[$];
  logic [W-1:0] m_word = '0, m_mask = '0;
  logic m_hold = 1'b0, m_err = 1'b0;
  int m_words = 0, pops = 0;

  word_bit_assembler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_mask(out_mask), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a word is a set of written positions; a beat completes it on in_last or when all positions are written.
  always @(negedge rst_n) begin
    m_words -= q.size();
    q.delete();
    m_word = '0;
    m_mask = '0;
    m_hold = 1'b0;
    m_err = 1'b0;
  end

  always @(posedge clk) if (rst_n === 1'b1) begin
    logic was_hold;
    was_hold = m_hold;
    m_err = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_word", 1, 0);
      else begin
        chk("sb_word", out_word, q[0].w);
        chk("sb_mask", out_mask, q[0].m);
        void'(q.pop_front());
        pops++;
      end
    end
    if (was_hold && out_ready) begin
      m_hold = 1'b0;
      m_word = '0;
      m_mask = '0;
    end
    if (!was_hold && in_valid) begin
      if (int'(in_idx) < W) begin
        m_word[in_idx] = in_bit;
        m_mask[in_idx] = 1'b1;
      end else m_err = 1'b1;
      if (in_last || m_mask == '1) begin
        q.push_back('{w: m_word, m: m_mask});
        m_words++;
        m_hold = 1'b1;
      end
    end
  end

  always @(negedge clk) if (rst_n === 1'b1) begin
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    chk("err_idx", err_idx, m_err);
    if (m_hold && q.size() > 0) begin
      chk("hold_word", out_word, q[0].w);
      chk("hold_mask", out_mask, q[0].m);
    end else if (!m_hold) chk("fill_mask", out_mask, m_mask);
  end

  task automatic beat(input int idx, input logic b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_idx = 5'(idx);
    in_bit = b;
    in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take;
    chk("take_out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("take_in_ready", in_ready, 1);
    chk("take_mask", out_mask, 0);
  endtask

  initial begin
    logic [W-1:0] v;
    int target, cyc;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_word", out_word, 0);
    chk("rst_err", err_idx, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    v = 16'habcd;
    for (int i = 0; i < W; i++) beat(i, v[i], 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_word", out_word, 16'habcd);
    chk("t1_mask", out_mask, 16'hffff);
    take();
    beat(3, 1'b1, 1'b0);
    beat(3, 1'b0, 1'b0);
    beat(5, 1'b1, 1'b1);
    chk("t2_word", out_word, 16'h0020);
    chk("t2_mask", out_mask, 16'h0028);
    take();
    beat(16, 1'b1, 1'b0);
    chk("t3_err", err_idx, 1);
    chk("t3_mask", out_mask, 0);
    chk("t3_word", out_word, 0);
    @(negedge clk);
    chk("t3_err_clear", err_idx, 0);
    beat(17, 1'b1, 1'b1);
    chk("t3_hold", out_valid, 1);
    chk("t3_hold_mask", out_mask, 0);
    take();
    beat(2, 1'b1, 1'b1);
    repeat (10) begin
      in_valid = 1'b1;
      in_idx = 5'd7;
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_word", out_word, 16'h0004);
    end
    in_valid = 1'b0;
    take();
    for (int i = 0; i < 8; i++) beat(i, 1'b1, 1'b0);
    chk("t5_partial", out_mask, 16'h00ff);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_mask", out_mask, 0);
    chk("t5_rst_word", out_word, 0);
    chk("t5_rst_valid", out_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    v = 16'($urandom);
    for (int i = 0; i < W; i++) beat(i, v[i], 1'b0);
    chk("t5_word", out_word, v);
    chk("t5_mask", out_mask, 16'hffff);
    take();
    target = m_words + 1000;
    cyc = 0;
    while (m_words < target && cyc < 60000) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_idx = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      in_bit = 1'($urandom_range(0, 1));
      in_last = $urandom_range(0, 15) == 0;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    chk("random_words_done", m_words >= target, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("words_vs_pops", pops, m_words);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
